// File: rtl/pc_source_unit.sv
// pc_source_unit
// Program-counter source unit for the multicycle CPU datapath. Picks the next
// PC from a packed set of candidate buses (one slot hardwired to the exception
// vector), loads it into the PC register on an unconditional or branch write,
// and handles exception redirection, EPC capture and error/alignment flags.
module pc_source_unit #(
  parameter int               WIDTH      = 32,
  parameter int               NUM_SRC    = 6,
  parameter int               SEL_W      = 3,
  parameter int               VEC_SLOT   = 3,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h0000_00FD,
  parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SEL_W-1:0]         pc_src,
  input  logic [NUM_SRC*WIDTH-1:0] data_in,
  input  logic                     pc_write,
  input  logic                     pc_write_cond,
  input  logic                     zero,
  input  logic                     cond_invert,
  input  logic                     exc,
  output logic [WIDTH-1:0]         next_pc,
  output logic [WIDTH-1:0]         pc_out,
  output logic [WIDTH-1:0]         epc_out,
  output logic                     sel_err,
  output logic                     misaligned
);

  // One extra bit so NUM_SRC == 2^SEL_W still compares correctly.
  localparam logic [SEL_W:0] NUM_SRC_W = (SEL_W + 1)'(NUM_SRC);

  logic [WIDTH-1:0] cand;
  logic             src_valid;
  logic             take;

  // Candidate mux: the vector slot is replaced by the exception address and
  // selectors beyond the last slot yield zero.
  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pc_src == SEL_W'(i)) begin
        if (i == VEC_SLOT) begin
          cand = EXC_VECTOR;
        end else begin
          cand = data_in[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Load decision and the combinational next-PC view seen by the datapath.
  always_comb begin
    src_valid = ({1'b0, pc_src} < NUM_SRC_W);
    take      = pc_write | (pc_write_cond & (zero ^ cond_invert));
    next_pc   = exc ? EXC_VECTOR : cand;
  end

  // PC, EPC and flag registers; priority is reset, then exception, then load.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out     <= RESET_PC;
      epc_out    <= '0;
      sel_err    <= 1'b0;
      misaligned <= 1'b0;
    end else if (exc) begin
      epc_out    <= pc_out;
      pc_out     <= EXC_VECTOR;
      misaligned <= |EXC_VECTOR[1:0];
    end else if (take) begin
      if (src_valid) begin
        pc_out     <= cand;
        misaligned <= |cand[1:0];
      end else begin
        sel_err    <= 1'b1;
        misaligned <= 1'b0;
      end
    end else begin
      misaligned <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_source_unit.sv
// Testbench for pc_source_unit: directed vectors with hand-computed results.
module tb_pc_source_unit;

  logic          clk;
  logic          reset;
  logic [2:0]    pc_src;
  logic [191:0]  data_in;
  logic          pc_write;
  logic          pc_write_cond;
  logic          zero;
  logic          cond_invert;
  logic          exc;
  logic [31:0]   next_pc;
  logic [31:0]   pc_out;
  logic [31:0]   epc_out;
  logic          sel_err;
  logic          misaligned;

  int compared   = 0;
  int mismatched = 0;

  pc_source_unit dut (
    .clk          (clk),
    .reset        (reset),
    .pc_src       (pc_src),
    .data_in      (data_in),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .zero         (zero),
    .cond_invert  (cond_invert),
    .exc          (exc),
    .next_pc      (next_pc),
    .pc_out       (pc_out),
    .epc_out      (epc_out),
    .sel_err      (sel_err),
    .misaligned   (misaligned)
  );

  // 10 ns free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive all control inputs and let the combinational path settle.
  task automatic applyStimulus(input logic rst, input logic ex, input logic pw,
                               input logic pwc, input logic z, input logic inv,
                               input logic [2:0] src);
    reset         = rst;
    exc           = ex;
    pc_write      = pw;
    pc_write_cond = pwc;
    zero          = z;
    cond_invert   = inv;
    pc_src        = src;
    #1;
  endtask

  // Advance one rising edge and sample 1 ns afterwards.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic setSlot(input int idx, input logic [31:0] val);
    data_in[idx*32 +: 32] = val;
  endtask

  task automatic checkAll(input string tag, input logic [31:0] pc,
                          input logic [31:0] epc, input logic serr,
                          input logic mis);
    checkOutput({tag, ".pc"},  pc_out,           pc);
    checkOutput({tag, ".epc"}, epc_out,          epc);
    checkOutput({tag, ".err"}, {31'b0, sel_err}, {31'b0, serr});
    checkOutput({tag, ".mis"}, {31'b0, misaligned}, {31'b0, mis});
  endtask

  logic [31:0] sweepExp [6];

  initial begin
    data_in = '0;
    for (int i = 0; i < 6; i++) setSlot(i, 32'h1000_0000 + 32'(4 * i));
    setSlot(3, 32'hDEAD_BEEF);
    sweepExp = '{32'h1000_0000, 32'h1000_0004, 32'h1000_0008,
                 32'h0000_00FD, 32'h1000_0010, 32'h1000_0014};

    // Reset then hold for three cycles.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    stepClock();
    checkAll("reset", 32'h0, 32'h0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      stepClock();
      checkAll("hold", 32'h0, 32'h0, 0, 0);
    end

    // Unconditional sweep over every slot.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 1, 0, 0, 0, 3'(i));
      checkOutput("sweep.next", next_pc, sweepExp[i]);
      stepClock();
      checkAll("sweep", sweepExp[i], 32'h0, 0, (i == 3));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    stepClock();
    checkOutput("sweep.misclr", {31'b0, misaligned}, 32'h0);

    // Conditional branch variants.
    setSlot(1, 32'h0000_0040);
    applyStimulus(0, 0, 0, 1, 1, 0, 1);
    stepClock();
    checkOutput("beq.taken", pc_out, 32'h0000_0040);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    stepClock();
    checkOutput("reload", pc_out, 32'h1000_0000);
    applyStimulus(0, 0, 0, 1, 1, 1, 1);
    stepClock();
    checkOutput("bne.nottaken", pc_out, 32'h1000_0000);
    applyStimulus(0, 0, 0, 1, 0, 0, 1);
    stepClock();
    checkOutput("beq.nottaken", pc_out, 32'h1000_0000);
    applyStimulus(0, 0, 0, 1, 0, 1, 1);
    stepClock();
    checkOutput("bne.taken", pc_out, 32'h0000_0040);
    applyStimulus(0, 0, 1, 1, 0, 0, 2);
    stepClock();
    checkOutput("both.writes", pc_out, 32'h1000_0008);

    // Exception with a competing load.
    setSlot(0, 32'h0000_0120);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    stepClock();
    checkOutput("exc.pre", pc_out, 32'h0000_0120);
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    checkOutput("exc.next", next_pc, 32'h0000_00FD);
    stepClock();
    checkAll("exc", 32'h0000_00FD, 32'h0000_0120, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    stepClock();
    checkAll("exc.after", 32'h0000_00FD, 32'h0000_0120, 0, 0);

    // Invalid selector on a load sets the sticky error.
    applyStimulus(0, 0, 1, 0, 0, 0, 7);
    checkOutput("bad.next", next_pc, 32'h0);
    stepClock();
    checkAll("bad7", 32'h0000_00FD, 32'h0000_0120, 1, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 2);
    stepClock();
    checkAll("bad.valid", 32'h1000_0008, 32'h0000_0120, 1, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 6);
    stepClock();
    checkAll("bad6", 32'h1000_0008, 32'h0000_0120, 1, 0);

    // Reset wins over exception and load.
    applyStimulus(1, 1, 1, 0, 0, 0, 2);
    stepClock();
    checkAll("rstprio", 32'h0, 32'h0, 0, 0);

    // Invalid selector without a load leaves the error clear.
    applyStimulus(0, 0, 0, 0, 0, 0, 7);
    stepClock();
    checkAll("bad.noload", 32'h0, 32'h0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 7);
    stepClock();
    checkAll("bad.condfail", 32'h0, 32'h0, 0, 0);

    // Exception held two cycles, then reset right after.
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    stepClock();
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    stepClock();
    checkOutput("exc2.epc1", epc_out, 32'h0000_0120);
    stepClock();
    checkOutput("exc2.epc2", epc_out, 32'h0000_00FD);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    stepClock();
    checkAll("exc2.rst", 32'h0, 32'h0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pc_source_unit.md
# pc_source_unit

Parametrised program-counter source unit for the multicycle CPU datapath. It selects the next PC from NUM_SRC packed candidate buses, with one slot hardwired to an exception-vector constant. The selected value is loaded into an internal PC register under unconditional or branch-conditional write control. Exception redirection, EPC capture, and registered error/alignment flags are built in.

## Interface

Parameters:
- WIDTH, 32, PC/data width in bits
- NUM_SRC, 6, number of selectable source slots (2..2^SEL_W)
- SEL_W, 3, selector width
- VEC_SLOT, 3, slot index whose data is replaced by EXC_VECTOR; its data_in bits are ignored
- EXC_VECTOR, 32'h0000_00FD, exception handler address, WIDTH bits
- RESET_PC, 32'h0000_0000, PC value after reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- pc_src  in  SEL_W  source select; slot i = data_in[i*WIDTH +: WIDTH]
- data_in  in  NUM_SRC*WIDTH  packed candidate next-PC values
- pc_write  in  1  unconditional PC load
- pc_write_cond  in  1  conditional PC load (branch)
- zero  in  1  ALU zero flag
- cond_invert  in  1  0: branch-if-zero (beq); 1: branch-if-nonzero (bne)
- exc  in  1  exception request; forces PC to EXC_VECTOR
- next_pc  out  WIDTH  combinational selected candidate (EXC_VECTOR when exc=1)
- pc_out  out  WIDTH  registered PC
- epc_out  out  WIDTH  registered exception PC
- sel_err  out  1  sticky flag: out-of-range pc_src used on a load
- misaligned  out  1  registered, 1 cycle: last loaded PC had bits [1:0] != 0

## Operation

- cand = EXC_VECTOR when pc_src == VEC_SLOT; 0 when pc_src >= NUM_SRC; data_in slot otherwise.
- take = pc_write | (pc_write_cond & (zero ^ cond_invert)).
- Priority each cycle: reset > exc > take > hold.
- reset: pc_out = RESET_PC, epc_out = 0, sel_err = 0, misaligned = 0. Reset overrides exc and take asserted in the same cycle.
- exc=1:
  - epc_out <= current pc_out (the value before the edge).
  - pc_out <= EXC_VECTOR. pc_src, pc_write and pc_write_cond are ignored.
  - misaligned <= (EXC_VECTOR[1:0] != 0).
  - sel_err is unchanged.
- take=1 with pc_src < NUM_SRC:
  - pc_out <= cand.
  - misaligned <= (cand[1:0] != 0). The misaligned value is still loaded; the flag is report-only.
- take=1 with pc_src >= NUM_SRC:
  - pc_out holds.
  - sel_err <= 1 and stays 1 until reset.
  - misaligned <= 0.
- No take and no exc: pc_out and epc_out hold; misaligned <= 0.
- pc_write and pc_write_cond both high: take=1 (OR). The condition is irrelevant.
- An out-of-range pc_src with take=0 does not set sel_err.
- epc_out changes only on exc or reset.
- Arithmetic: none. All values pass through unmodified at WIDTH bits; no sign/zero extension inside the block.

## Timing

- next_pc is combinational from pc_src, data_in and exc; zero-cycle latency.
- pc_out, epc_out, sel_err and misaligned are all registered; one-cycle latency from inputs to outputs.
- A load sampled at edge N is visible on pc_out after edge N; there is no bypass.
- Back-to-back loads on consecutive cycles are each applied; no throughput limit.
- Reset asserted mid-sequence (e.g. the cycle after exc) takes effect at the next edge, regardless of other inputs.
- exc held high for k cycles:
  - Cycle 1: epc_out captures the pre-exception PC.
  - Later cycles: epc_out captures EXC_VECTOR (the current pc_out). Single-cycle exc pulses are the contract with the control FSM.

## Test plan

- Reset then hold: reset=1 for one edge, then all controls 0 for 3 cycles -> pc_out=0, epc_out=0, sel_err=0, misaligned=0 throughout.
- Unconditional sweep: pc_write=1, pc_src=0..5, slot i = 32'h1000_0000+4*i -> pc_out after each edge equals its slot. For pc_src=3, pc_out=32'h0000_00FD and misaligned=1 for one cycle.
- Conditional branch: pc_write_cond=1, pc_src=1, slot1=32'h0000_0040:
  - zero=1, cond_invert=0 -> pc_out=32'h40.
  - zero=1, cond_invert=1 -> pc_out holds.
  - zero=0, cond_invert=1 -> pc_out=32'h40.
- Exception: pc_out=32'h0000_0120, exc=1 with pc_write=1, pc_src=0 for one cycle -> pc_out=32'h0000_00FD and epc_out=32'h0000_0120 after the edge; epc_out holds afterwards.
- Invalid select: pc_src=7, pc_write=1 -> pc_out unchanged, sel_err=1 and stays 1 through later valid loads. Repeat with pc_write=0 from reset -> sel_err stays 0.
- Reset priority: reset=1 together with exc=1 and pc_write=1 -> pc_out=RESET_PC, epc_out=0, sel_err cleared.
